// File: rtl/mealy_decoder.sv
// ---------------------------------------------------------------------------
// mealy_decoder
//
// Receive-side decoder for a 3-state one-hot rotating Mealy encoder. One
// 3-bit symbol is sampled on every clock where z_valid is high. From it the
// decoder rebuilds the encoder's one-hot state and its rotation direction.
// It also flags illegal or out-of-sequence symbols, counts errors, and
// re-locks on its own.
//
// Ports
//   clock      : rising-edge clock
//   reset_n    : asynchronous, active-low reset
//   z_in       : encoder output symbol
//   z_valid    : z_in is sampled on this edge
//   state_out  : tracked encoder state, one-hot (s0=001, s1=010, s2=100)
//   dir_out    : decoded direction, 0 = clockwise, 1 = counter-clockwise
//   dir_valid  : one-cycle pulse, dir_out is meaningful this cycle
//   locked     : decoder is in LOCKED
//   sym_err    : one-cycle pulse, the last sampled symbol was in error
//   err_count  : total errors since reset, saturating at all-ones
// ---------------------------------------------------------------------------
module mealy_decoder #(
    parameter int ERR_W    = 8,
    parameter int MAX_ERRS = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       z_in,
    input  logic             z_valid,
    output logic [2:0]       state_out,
    output logic             dir_out,
    output logic             dir_valid,
    output logic             locked,
    output logic             sym_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} fsm_t;

    localparam logic [2:0] S0 = 3'b001;
    localparam logic [2:0] S1 = 3'b010;
    localparam logic [2:0] S2 = 3'b100;
    localparam logic [2:0] MAX_ERRS_L = 3'(MAX_ERRS);
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    fsm_t             fsm_reg, fsm_next;
    logic [2:0]       st_reg, st_next;
    logic [2:0]       cerr_reg, cerr_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;
    logic             dir_out_reg, dir_out_next;
    logic             dir_valid_reg, dir_valid_next;
    logic             sym_err_reg, sym_err_next;

    // Symbol / state classification shared by the next-state and output logic
    logic       sym_legal;
    logic [2:0] sym_st;      // state the encoder must be in after this symbol
    logic       st_onehot;
    logic [2:0] cw_sym;      // symbol emitted from st_reg when a_in == 0
    logic [2:0] ccw_sym;     // symbol emitted from st_reg when a_in != 0
    logic       is_cw, is_ccw;
    logic       tracking;    // LOCKED with a sane state register
    logic [2:0] cerr_inc;

    always_comb begin
        sym_legal = 1'b1;
        sym_st    = st_reg;
        case (z_in)
            3'b110:  sym_st = S1;
            3'b111:  sym_st = S2;
            3'b101:  sym_st = S0;
            default: sym_legal = 1'b0;
        endcase

        st_onehot = 1'b1;
        cw_sym    = 3'b000;
        ccw_sym   = 3'b000;
        case (st_reg)
            S0: begin cw_sym = 3'b110; ccw_sym = 3'b111; end
            S1: begin cw_sym = 3'b111; ccw_sym = 3'b101; end
            S2: begin cw_sym = 3'b101; ccw_sym = 3'b110; end
            default: st_onehot = 1'b0;
        endcase

        is_cw    = st_onehot && (z_in == cw_sym);
        is_ccw   = st_onehot && (z_in == ccw_sym);
        tracking = (fsm_reg == LOCKED) && st_onehot;
        cerr_inc = cerr_reg + 3'd1;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg       <= HUNT;
            st_reg        <= S0;
            cerr_reg      <= 3'd0;
            err_count_reg <= '0;
            dir_out_reg   <= 1'b0;
            dir_valid_reg <= 1'b0;
            sym_err_reg   <= 1'b0;
        end else begin
            fsm_reg       <= fsm_next;
            st_reg        <= st_next;
            cerr_reg      <= cerr_next;
            err_count_reg <= err_count_next;
            dir_out_reg   <= dir_out_next;
            dir_valid_reg <= dir_valid_next;
            sym_err_reg   <= sym_err_next;
        end
    end

    // Next-state logic: control FSM, tracked state and consecutive errors
    always_comb begin
        fsm_next  = fsm_reg;
        st_next   = st_reg;
        cerr_next = cerr_reg;
        if (z_valid) begin
            if (!tracking) begin
                // HUNT (or a corrupted state register): one legal symbol
                // fully determines the encoder state.
                if (sym_legal) begin
                    st_next   = sym_st;
                    fsm_next  = LOCKED;
                    cerr_next = 3'd0;
                end else begin
                    fsm_next  = HUNT;
                end
            end else if (is_cw || is_ccw) begin
                st_next   = sym_st;
                cerr_next = 3'd0;
            end else begin
                // Legal-but-unexpected resyncs at once; invalid codes hold.
                if (sym_legal) begin
                    st_next = sym_st;
                end
                if (cerr_inc >= MAX_ERRS_L) begin
                    fsm_next  = HUNT;
                    cerr_next = 3'd0;
                end else begin
                    cerr_next = cerr_inc;
                end
            end
        end
    end

    // Output logic: values to be registered onto the outputs
    always_comb begin
        dir_valid_next = 1'b0;
        sym_err_next   = 1'b0;
        dir_out_next   = dir_out_reg;
        err_count_next = err_count_reg;
        if (z_valid && tracking) begin
            if (is_cw) begin
                dir_valid_next = 1'b1;
                dir_out_next   = 1'b0;
            end else if (is_ccw) begin
                dir_valid_next = 1'b1;
                dir_out_next   = 1'b1;
            end else begin
                sym_err_next = 1'b1;
                if (err_count_reg != '1) begin
                    err_count_next = err_count_reg + ERR_ONE;
                end
            end
        end
    end

    assign state_out = st_reg;
    assign dir_out   = dir_out_reg;
    assign dir_valid = dir_valid_reg;
    assign locked    = (fsm_reg == LOCKED);
    assign sym_err   = sym_err_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_mealy_decoder.sv
// ---------------------------------------------------------------------------
// tb_mealy_decoder
//
// Self-checking bench for mealy_decoder. Two instances share the stimulus:
// dut (default parameters) and dut_sat (ERR_W = 2), which exercises counter
// saturation. Expected output snapshots go into a queue as each symbol is
// driven. They are popped and compared at the falling edge that follows the
// sampling edge. dir_out is only compared while dir_valid is high.
// ---------------------------------------------------------------------------
module tb_mealy_decoder;

    typedef struct packed {
        logic [2:0] st;
        logic       dir_out;
        logic       dir_valid;
        logic       locked;
        logic       sym_err;
        logic [7:0] errc;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] z_in = 3'b000;
    logic       z_valid = 1'b0;

    logic [2:0] state_out, state_out_s;
    logic       dir_out, dir_valid, locked, sym_err;
    logic       dir_out_s, dir_valid_s, locked_s, sym_err_s;
    logic [7:0] err_count;
    logic [1:0] err_count_s;

    int n_checks = 0;
    int n_fail   = 0;
    obs_t exp_q[$];

    always #5 clock = ~clock;

    mealy_decoder dut (
        .clock(clock), .reset_n(reset_n), .z_in(z_in), .z_valid(z_valid),
        .state_out(state_out), .dir_out(dir_out), .dir_valid(dir_valid),
        .locked(locked), .sym_err(sym_err), .err_count(err_count)
    );

    mealy_decoder #(.ERR_W(2), .MAX_ERRS(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .z_in(z_in), .z_valid(z_valid),
        .state_out(state_out_s), .dir_out(dir_out_s), .dir_valid(dir_valid_s),
        .locked(locked_s), .sym_err(sym_err_s), .err_count(err_count_s)
    );

    function automatic obs_t mk(input logic [2:0] st, input logic d, input logic dv,
                                input logic lk, input logic se, input logic [7:0] ec);
        obs_t o;
        o.st = st; o.dir_out = d & dv; o.dir_valid = dv;
        o.locked = lk; o.sym_err = se; o.errc = ec;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(state_out, dir_out, dir_valid, locked, sym_err, err_count);
    endfunction

    function automatic obs_t observe_sat();
        return mk(state_out_s, dir_out_s, dir_valid_s, locked_s, sym_err_s, {6'd0, err_count_s});
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%b dir=%b dv=%b lk=%b se=%b ec=%0d",
                         o.st, o.dir_out, o.dir_valid, o.locked, o.sym_err, o.errc);
    endfunction

    // Drive one symbol (or an idle cycle) and return at the next falling edge.
    task automatic drive(input logic [2:0] z, input logic v);
        z_in = z;
        z_valid = v;
        @(negedge clock);
        z_valid = 1'b0;
        z_in = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        z_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        obs_t got, want;
        // Reset held while clocking a legal symbol: nothing may move.
        reset_n = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(3'b001, 0, 0, 0, 0, 0));
            drive(3'b110, 1'b1);
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_hold[%0d] got %s expected %s", i, fmt(got), fmt(want));
            end
        end
        reset_n = 1'b1;
        // Idle cycle, then an invalid code in HUNT: still reset values.
        exp_q.push_back(mk(3'b001, 0, 0, 0, 0, 0));
        drive(3'b000, 1'b0);
        exp_q.push_back(mk(3'b001, 0, 0, 0, 0, 0));
        drive(3'b011, 1'b1);
        for (int i = 0; i < 2; i++) begin
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_hunt_idle[%0d] got %s expected %s", i, fmt(got), fmt(want));
            end
            exp_q.push_back(want);
        end
        exp_q.delete();
        $display("test_reset: done");
    endtask

    task automatic test_lock_cw();
        logic [2:0] zs[4] = '{3'b110, 3'b111, 3'b101, 3'b110};
        obs_t es[4];
        obs_t got, want;
        es[0] = mk(3'b010, 0, 0, 1, 0, 0);
        es[1] = mk(3'b100, 0, 1, 1, 0, 0);
        es[2] = mk(3'b001, 0, 1, 1, 0, 0);
        es[3] = mk(3'b010, 0, 1, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(es[i]);
            drive(zs[i], 1'b1);
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL lock_cw[%0d] got %s expected %s", i, fmt(got), fmt(want));
            end
        end
        $display("test_lock_cw: done");
    endtask

    task automatic test_ccw();
        logic [2:0] zs[4] = '{3'b101, 3'b111, 3'b110, 3'b101};
        obs_t es[4];
        obs_t got, want;
        es[0] = mk(3'b001, 0, 0, 1, 0, 0);
        es[1] = mk(3'b100, 1, 1, 1, 0, 0);
        es[2] = mk(3'b010, 1, 1, 1, 0, 0);
        es[3] = mk(3'b001, 1, 1, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(es[i]);
            drive(zs[i], 1'b1);
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL ccw[%0d] got %s expected %s", i, fmt(got), fmt(want));
            end
        end
        $display("test_ccw: done");
    endtask

    task automatic test_unexpected();
        // The final 000 + 111 show that cerr was cleared by the good 110:
        // a second error then must not drop lock.
        logic [2:0] zs[5] = '{3'b101, 3'b101, 3'b110, 3'b000, 3'b111};
        obs_t es[5];
        obs_t got, want;
        es[0] = mk(3'b001, 0, 0, 1, 0, 0);
        es[1] = mk(3'b001, 0, 0, 1, 1, 1);
        es[2] = mk(3'b010, 0, 1, 1, 0, 1);
        es[3] = mk(3'b010, 0, 0, 1, 1, 2);
        es[4] = mk(3'b100, 0, 1, 1, 0, 2);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(es[i]);
            drive(zs[i], 1'b1);
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL unexpected[%0d] got %s expected %s", i, fmt(got), fmt(want));
            end
        end
        $display("test_unexpected: done");
    endtask

    task automatic test_lock_loss();
        logic [2:0] zs[5] = '{3'b110, 3'b000, 3'b011, 3'b000, 3'b000};
        logic       vs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        obs_t es[5];
        obs_t got, want;
        es[0] = mk(3'b010, 0, 0, 1, 0, 0);
        es[1] = mk(3'b010, 0, 0, 1, 1, 1);
        es[2] = mk(3'b010, 0, 0, 0, 1, 2);
        es[3] = mk(3'b010, 0, 0, 0, 0, 2);
        es[4] = mk(3'b010, 0, 0, 0, 0, 2);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(es[i]);
            drive(zs[i], vs[i]);
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL lock_loss[%0d] got %s expected %s", i, fmt(got), fmt(want));
            end
        end
        $display("test_lock_loss: done");
    endtask

    task automatic test_saturation();
        // Runs on the ERR_W=2 instance. Each round: an invalid code, a 3-cycle
        // idle gap, then the clockwise symbol for the held state to resync.
        logic [2:0] cw_tab[3] = '{3'b110, 3'b111, 3'b101};
        int         idx;
        logic [7:0] ec;
        obs_t got, want;
        do_reset();
        exp_q.push_back(mk(3'b010, 0, 0, 1, 0, 0));
        drive(3'b110, 1'b1);
        got = observe_sat(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL sat_lock got %s expected %s", fmt(got), fmt(want));
        end
        idx = 1;
        ec = 0;
        for (int r = 0; r < 5; r++) begin
            if (ec < 3) ec++;
            exp_q.push_back(mk(3'b001 << idx, 0, 0, 1, 1, ec));
            drive(3'b000, 1'b1);
            got = observe_sat(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL sat_err[%0d] got %s expected %s", r, fmt(got), fmt(want));
            end
            for (int g = 0; g < 3; g++) begin
                exp_q.push_back(mk(3'b001 << idx, 0, 0, 1, 0, ec));
                drive(3'b111, 1'b0);
                got = observe_sat(); want = exp_q.pop_front(); n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL sat_gap[%0d.%0d] got %s expected %s", r, g, fmt(got), fmt(want));
                end
            end
            idx = (idx + 1) % 3;
            exp_q.push_back(mk(3'b001 << idx, 0, 1, 1, 0, ec));
            drive(cw_tab[(idx + 2) % 3], 1'b1);
            got = observe_sat(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL sat_resync[%0d] got %s expected %s", r, fmt(got), fmt(want));
            end
        end
        $display("test_saturation: done");
    endtask

    task automatic test_async_reset();
        logic [2:0] zs[6] = '{3'b110, 3'b000, 3'b111, 3'b000, 3'b101, 3'b000};
        obs_t es[6];
        obs_t got, want;
        es[0] = mk(3'b010, 0, 0, 1, 0, 0);
        es[1] = mk(3'b010, 0, 0, 1, 1, 1);
        es[2] = mk(3'b100, 0, 1, 1, 0, 1);
        es[3] = mk(3'b100, 0, 0, 1, 1, 2);
        es[4] = mk(3'b001, 0, 1, 1, 0, 2);
        es[5] = mk(3'b001, 0, 0, 1, 1, 3);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(es[i]);
            drive(zs[i], 1'b1);
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL async_prep[%0d] got %s expected %s", i, fmt(got), fmt(want));
            end
        end
        // Assert reset between edges; outputs must clear before the next edge.
        #2 reset_n = 1'b0;
        exp_q.push_back(mk(3'b001, 0, 0, 0, 0, 0));
        #1;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_clear got %s expected %s", fmt(got), fmt(want));
        end
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back(mk(3'b001, 0, 0, 1, 0, 0));
        drive(3'b101, 1'b1);
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_relock got %s expected %s", fmt(got), fmt(want));
        end
        $display("test_async_reset: done");
    endtask

    task automatic test_back_to_back();
        // Random symbols at near full rate against a small behavioural model
        // that walks the encoder law by state index.
        logic [2:0] pool[5]   = '{3'b000, 3'b101, 3'b110, 3'b111, 3'b011};
        logic [2:0] cw_tab[3] = '{3'b110, 3'b111, 3'b101};
        logic [2:0] ccw_tab[3] = '{3'b111, 3'b101, 3'b110};
        int m_idx = 0, m_cerr = 0, sidx;
        logic m_lk = 0, dv, se, d, v;
        logic [7:0] m_ec = 0;
        logic [2:0] z;
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            z = pool[$urandom_range(0, 4)];
            v = ($urandom_range(0, 7) != 0);
            dv = 0; se = 0; d = 0;
            sidx = (z == 3'b101) ? 0 : (z == 3'b110) ? 1 : (z == 3'b111) ? 2 : -1;
            if (v) begin
                if (!m_lk) begin
                    if (sidx >= 0) begin
                        m_idx = sidx; m_lk = 1; m_cerr = 0;
                    end
                end else if (z == cw_tab[m_idx]) begin
                    dv = 1; d = 0; m_idx = (m_idx + 1) % 3; m_cerr = 0;
                end else if (z == ccw_tab[m_idx]) begin
                    dv = 1; d = 1; m_idx = (m_idx + 2) % 3; m_cerr = 0;
                end else begin
                    se = 1;
                    if (m_ec != 8'hFF) m_ec++;
                    if (sidx >= 0) m_idx = sidx;
                    m_cerr++;
                    if (m_cerr >= 2) begin
                        m_lk = 0; m_cerr = 0;
                    end
                end
            end
            exp_q.push_back(mk(3'b001 << m_idx, d, dv, m_lk, se, m_ec));
            drive(z, v);
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] z=%b v=%b got %s expected %s",
                         i, z, v, fmt(got), fmt(want));
            end
        end
        $display("test_back_to_back: done");
    endtask

    initial begin
        test_reset();
        test_lock_cw();
        test_ccw();
        test_unexpected();
        test_lock_loss();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mealy_decoder.md
# mealy_decoder

Receive-side decoder for the 3-state one-hot rotating Mealy encoder's output stream. Samples one 3-bit output symbol per valid clock and reconstructs the encoder's one-hot state and its rotation direction (the encoder's `a_in == 0` vs `a_in != 0`). Detects illegal and out-of-sequence symbols, counts errors, and re-locks automatically. Sits at the far end of the symbol link, directly consuming what the encoder drives on `z_out`.

## Interface

- `ERR_W`, default 8: width of the saturating error counter.
- `MAX_ERRS`, default 2: consecutive errors in LOCKED that force a drop to HUNT; legal range is 1 to 7.
- `clock`, input, 1: single clock, rising-edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `z_in`, input, 3: encoder output symbol.
- `z_valid`, input, 1: `z_in` is sampled on this clock edge.
- `state_out`, output, 3: tracked encoder state, one-hot, with s0=001, s1=010, s2=100.
- `dir_out`, output, 1: decoded direction; 0 = clockwise (`a_in == 0`), 1 = counter-clockwise.
- `dir_valid`, output, 1: one-cycle pulse; `dir_out` is meaningful this cycle.
- `locked`, output, 1: decoder is in LOCKED.
- `sym_err`, output, 1: one-cycle pulse; the last sampled symbol was in error.
- `err_count`, output, ERR_W: total errors since reset, saturating at all-ones.

## Operation

- **Encoder law.** The decoder inverts this law. Each entry gives the symbol and next state for the clockwise case, then for the counter-clockwise case.
  - s0: clockwise 110 -> s1; counter-clockwise 111 -> s2.
  - s1: clockwise 111 -> s2; counter-clockwise 101 -> s0.
  - s2: clockwise 101 -> s0; counter-clockwise 110 -> s1.
- **Legal code set** is {101, 110, 111}. Every other value, including the encoder's reset value 000, is an invalid code.
- **Next state depends only on the symbol:** 110 -> s1, 111 -> s2, 101 -> s0. Resync therefore needs only one legal symbol.
- **Control FSM** has two states, HUNT and LOCKED. It also holds the register `st` (one-hot, drives `state_out`) and a consecutive-error counter `cerr` (3 bits).
- **HUNT:**
  - Legal symbol: `st` <= next state for that symbol; go to LOCKED; `cerr` <= 0; no `dir_valid` (direction is ambiguous); no error.
  - Invalid code: stay in HUNT; `st` is held; no `sym_err` and no count (idle or garbage is expected while hunting).
- **LOCKED, expected symbol** (one of the two symbols listed for the current `st`):
  - `dir_valid` = 1.
  - `dir_out` = 0 if the symbol is the clockwise symbol, 1 if it is the counter-clockwise symbol.
  - `st` advances to the next state; `cerr` <= 0.
- **LOCKED, legal but unexpected symbol** (the third legal code for this `st`):
  - `sym_err` = 1; `err_count`++; `cerr`++; no `dir_valid`.
  - `st` <= next state for that symbol (immediate resync).
- **LOCKED, invalid code:**
  - `sym_err` = 1; `err_count`++; `cerr`++; no `dir_valid`; `st` is held.
- **Dropping lock:** if `cerr` reaches MAX_ERRS, the FSM goes to HUNT on that same edge and `cerr` <= 0.
- **`z_valid` = 0:** no state change; all pulse outputs are 0.
- **`st` corruption** (value not one-hot): treat as HUNT on the next valid symbol. This branch is defensive only and is never expected in operation.

## Timing

- **Reset values** (while `reset_n` = 0):
  - `state_out` = 001.
  - `dir_out`, `dir_valid`, `locked`, `sym_err` = 0.
  - `err_count` = 0.
  - FSM = HUNT, `cerr` = 0.
- All outputs are registered. A symbol sampled at edge N is reflected on the outputs after edge N; latency is 1 clock.
- `dir_valid` and `sym_err` are never both 1. Each is high for exactly one cycle per sampled symbol.
- `locked` rises on the edge that samples the first legal symbol in HUNT. It falls on the edge of the MAX_ERRS-th consecutive error.
- `err_count` holds at 2^ERR_W - 1 once saturated; it never wraps.
- Asserting `reset_n` mid-stream clears everything immediately, without waiting for a clock edge. The first valid symbol after release is treated as a HUNT symbol.
- Back-to-back `z_valid` is supported at full rate with no bubbles.

## Test plan

1. **Reset and lock.** Reset, then send 110, 111, 101, 110.
   - After the 1st symbol: `locked`=1, `state_out`=010, `dir_valid`=0.
   - The next three symbols each give `dir_valid`=1 with `dir_out`=0.
   - Final `state_out` = 010.
2. **Counter-clockwise.** Lock with 101 (`st`=s0), then send 111, 110, 101.
   - Each gives `dir_out`=1 and `dir_valid`=1.
   - `state_out` sequence: 100, 010, 001.
3. **Unexpected legal symbol.** Lock with 101 (s0), then send 101.
   - `sym_err`=1, `err_count`=1, `state_out`=001, `locked`=1.
   - Next send 110: `dir_valid`=1, `dir_out`=0, `cerr` cleared.
4. **Lock loss.** With MAX_ERRS=2, while locked send 000 then 011.
   - Two `sym_err` pulses; `err_count`=2.
   - `locked`=0 after the second; `state_out` is unchanged.
   - Then send 000 in HUNT: no `sym_err`, `err_count` stays 2.
5. **Saturation and gaps.** With ERR_W=2, inject 5 spaced invalid codes, re-locking between them.
   - `err_count` reads 1, 2, 3, 3, 3.
   - With `z_valid`=0 idle gaps of 3 cycles, outputs hold and no pulses occur.
6. **Async reset mid-stream.** Drive `reset_n` low between clock edges while locked with `err_count`=3.
   - All outputs reach their reset values before the next rising edge.
